// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the single-bus datapath.
//   - alu_op_e    : ALU operation codes (0-9 single-cycle, A/B multi-cycle, C-F give 0)
//   - eng_state_e : multiply/divide engine states
//   - mem_state_e : memory handshake states
//   - Src*        : bit positions of each bus source inside the drive-select vector
package datapath_pkg;

    typedef enum logic [3:0] {
        AluAdd = 4'h0,
        AluSub = 4'h1,
        AluAnd = 4'h2,
        AluOr  = 4'h3,
        AluShr = 4'h4,
        AluShl = 4'h5,
        AluRor = 4'h6,
        AluRol = 4'h7,
        AluNeg = 4'h8,
        AluNot = 4'h9,
        AluMul = 4'hA,
        AluDiv = 4'hB
    } alu_op_e;

    typedef enum logic [1:0] {
        EngIdle,
        EngRun,
        EngDivZero
    } eng_state_e;

    typedef enum logic {
        MemIdle,
        MemWait
    } mem_state_e;

    // Bus sources; GPRs occupy SrcGprBase upward.
    localparam int unsigned SrcHi      = 0;
    localparam int unsigned SrcLo      = 1;
    localparam int unsigned SrcPc      = 2;
    localparam int unsigned SrcZHigh   = 3;
    localparam int unsigned SrcZLow    = 4;
    localparam int unsigned SrcMdr     = 5;
    localparam int unsigned SrcInport  = 6;
    localparam int unsigned SrcC       = 7;
    localparam int unsigned SrcGprBase = 8;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == AluMul) || (op == AluDiv);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply / divide engine (shift-add, restoring divide).
// Optional feature: define DATAPATH_SIGNED_MULDIV_EN for two's-complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start, is_div       launch request (ignored while busy), divide select
//   a, b                operands (a op b), sampled with start
//   busy, done, dz      running; one-cycle completion pulse; divide-by-zero flag
//   res_we, result      combinational write strobe and value for the final edge
module muldiv_seq
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  is_div,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic                  dz,
    output logic                  res_we,
    output logic [2*DATA_W-1:0]   result
);

    localparam int unsigned CntW = $clog2(DATA_W);
`ifdef DATAPATH_SIGNED_MULDIV_EN
    localparam bit Signed = 1'b1;
`else
    localparam bit Signed = 1'b0;
`endif

    eng_state_e          state_q, state_d;
    logic [2*DATA_W-1:0] work_q, work_d;      // MUL: {partial, multiplier}; DIV: {rem, quo}
    logic [DATA_W-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                div_q, div_d;
    logic                neg_lo_q, neg_lo_d;  // negate product / quotient at the end
    logic                neg_hi_q, neg_hi_d;  // negate remainder at the end
    logic                done_q, done_d;
    logic                dz_q, dz_d;

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] step_next;
    logic [DATA_W-1:0]   fix_hi, fix_lo;

    // One iteration of either algorithm, plus the sign fix-up of its outcome.
    always_comb begin
        a_neg     = Signed && a[DATA_W-1];
        b_neg     = Signed && b[DATA_W-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        mul_sum   = {1'b0, work_q[2*DATA_W-1:DATA_W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = work_q[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_q};

        if (!div_q) begin
            step_next = {mul_sum, work_q[DATA_W-1:1]};
        end else if (div_trial[DATA_W]) begin
            // Trial subtraction went negative: restore, quotient bit 0.
            step_next = {work_q[2*DATA_W-2:0], 1'b0};
        end else begin
            step_next = {div_trial[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};
        end

        fix_hi = step_next[2*DATA_W-1:DATA_W];
        fix_lo = step_next[DATA_W-1:0];
        if (div_q) begin
            if (neg_hi_q) fix_hi = -step_next[2*DATA_W-1:DATA_W];
            if (neg_lo_q) fix_lo = -step_next[DATA_W-1:0];
        end else if (neg_lo_q) begin
            {fix_hi, fix_lo} = -step_next;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        res_we   = 1'b0;
        result   = {fix_hi, fix_lo};

        unique case (state_q)
            EngIdle: begin
                if (start) begin
                    div_d = is_div;
                    if (is_div && (b == '0)) begin
                        state_d  = EngDivZero;
                        work_d   = {a, {DATA_W{1'b1}}};
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                    end else begin
                        state_d  = EngRun;
                        work_d   = {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
                        opnd_d   = is_div ? b_mag : a_mag;
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg && is_div;
                        cnt_d    = CntW'(DATA_W - 1);
                    end
                end
            end
            EngRun: begin
                work_d = step_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = EngIdle;
                    res_we  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            EngDivZero: begin
                state_d = EngIdle;
                res_we  = 1'b1;
                result  = work_q;
                done_d  = 1'b1;
                dz_d    = 1'b1;
            end
            default: state_d = EngIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= EngIdle;
            work_q   <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy = (state_q != EngIdle);
    assign done = done_q;
    assign dz   = dz_q;

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: single-bus CPU datapath with GPR file, special registers, ALU,
// multi-cycle MUL/DIV (muldiv_seq) and a req/ack memory port.
// Optional feature: DATAPATH_SIGNED_MULDIV_EN selects signed MUL/DIV (see muldiv_seq).
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   gpr_in/gpr_out                    per-GPR load enable / bus drive select
//   hi/lo/pc/ir/y/mar/z/mdr_in        special register load enables
//   hi/lo/pc/z_high/z_low/mdr/inport/c_out  bus drive selects
//   inport_data, c_data               external bus sources
//   alu_op, inc_pc, alu_start         ALU control
//   alu_busy, alu_done, alu_dz        engine status
//   mem_rd, mem_wr, mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack, mem_busy
//   bus_data, ir_data, bus_err        observation outputs
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_GPR = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_GPR-1:0] gpr_in,
    input  logic [NUM_GPR-1:0] gpr_out,
    input  logic               hi_in,
    input  logic               lo_in,
    input  logic               pc_in,
    input  logic               ir_in,
    input  logic               y_in,
    input  logic               mar_in,
    input  logic               z_in,
    input  logic               mdr_in,
    input  logic               hi_out,
    input  logic               lo_out,
    input  logic               pc_out,
    input  logic               z_high_out,
    input  logic               z_low_out,
    input  logic               mdr_out,
    input  logic               inport_out,
    input  logic               c_out,
    input  logic [DATA_W-1:0]  inport_data,
    input  logic [DATA_W-1:0]  c_data,
    input  logic [3:0]         alu_op,
    input  logic               inc_pc,
    input  logic               alu_start,
    output logic               alu_busy,
    output logic               alu_done,
    output logic               alu_dz,
    input  logic               mem_rd,
    input  logic               mem_wr,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               mem_busy,
    output logic [DATA_W-1:0]  bus_data,
    output logic [DATA_W-1:0]  ir_data,
    output logic               bus_err
);

    localparam int unsigned NumSrc = SrcGprBase + NUM_GPR;
    localparam int unsigned ShW    = $clog2(DATA_W);

    logic [DATA_W-1:0]   gpr_q [NUM_GPR];
    logic [DATA_W-1:0]   hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
    logic [2*DATA_W-1:0] z_q;

    // ---------------- bus ----------------
    logic [NumSrc-1:0] bus_sel;
    logic [DATA_W-1:0] bus_src [NumSrc];
    logic [DATA_W-1:0] bus_or;

    always_comb begin
        bus_sel                          = '0;
        bus_sel[SrcHi]                   = hi_out;
        bus_sel[SrcLo]                   = lo_out;
        bus_sel[SrcPc]                   = pc_out;
        bus_sel[SrcZHigh]                = z_high_out;
        bus_sel[SrcZLow]                 = z_low_out;
        bus_sel[SrcMdr]                  = mdr_out;
        bus_sel[SrcInport]               = inport_out;
        bus_sel[SrcC]                    = c_out;
        bus_sel[SrcGprBase +: NUM_GPR]   = gpr_out;
    end

    always_comb begin
        bus_src[SrcHi]     = hi_q;
        bus_src[SrcLo]     = lo_q;
        bus_src[SrcPc]     = pc_q;
        bus_src[SrcZHigh]  = z_q[2*DATA_W-1:DATA_W];
        bus_src[SrcZLow]   = z_q[DATA_W-1:0];
        bus_src[SrcMdr]    = mdr_q;
        bus_src[SrcInport] = inport_data;
        bus_src[SrcC]      = c_data;
        for (int i = 0; i < NUM_GPR; i++) begin
            bus_src[SrcGprBase + i] = gpr_q[i];
        end
    end

    always_comb begin
        bus_or = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (bus_sel[i]) bus_or = bus_or | bus_src[i];
        end
    end

    // Contention or no driver both yield 0; only contention flags an error.
    assign bus_data = $onehot(bus_sel) ? bus_or : '0;
    assign bus_err  = (|bus_sel) && !$onehot(bus_sel);

    // ---------------- single-cycle ALU ----------------
    logic [DATA_W-1:0] alu_a;
    logic [ShW-1:0]    shamt;
    logic [DATA_W-1:0] alu_res;

    assign alu_a = inc_pc ? DATA_W'(4) : y_q;
    assign shamt = bus_data[ShW-1:0];

    // NEG and NOT are unary on the bus operand.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            AluAdd:  alu_res = alu_a + bus_data;
            AluSub:  alu_res = alu_a - bus_data;
            AluAnd:  alu_res = alu_a & bus_data;
            AluOr:   alu_res = alu_a | bus_data;
            AluShr:  alu_res = alu_a >> shamt;
            AluShl:  alu_res = alu_a << shamt;
            AluRor:  alu_res = DATA_W'({alu_a, alu_a} >> shamt);
            AluRol:  alu_res = DATA_W'(({alu_a, alu_a} << shamt) >> DATA_W);
            AluNeg:  alu_res = -bus_data;
            AluNot:  alu_res = ~bus_data;
            default: alu_res = '0;
        endcase
    end

    // ---------------- multiply / divide engine ----------------
    logic                eng_start;
    logic                eng_res_we;
    logic [2*DATA_W-1:0] eng_result;

    assign eng_start = alu_start && is_muldiv(alu_op);

    muldiv_seq #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (eng_start),
        .is_div  (alu_op == AluDiv),
        .a       (alu_a),
        .b       (bus_data),
        .busy    (alu_busy),
        .done    (alu_done),
        .dz      (alu_dz),
        .res_we  (eng_res_we),
        .result  (eng_result)
    );

    // ---------------- memory handshake ----------------
    mem_state_e        mem_state_q, mem_state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rd_ack;
    logic              rd_pending;

    always_comb begin
        mem_state_d = mem_state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        unique case (mem_state_q)
            MemIdle: begin
                if (mem_rd || mem_wr) begin
                    mem_state_d = MemWait;
                    addr_d      = mar_q;
                    wdata_d     = mdr_q;
                    we_d        = mem_wr;
                end
            end
            MemWait: begin
                if (mem_ack) mem_state_d = MemIdle;
            end
            default: mem_state_d = MemIdle;
        endcase
    end

    assign mem_req    = (mem_state_q == MemWait);
    assign mem_busy   = mem_req;
    assign mem_we     = mem_req && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign rd_pending = mem_req && !we_q;
    assign rd_ack     = rd_pending && mem_ack;

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            pc_q        <= '0;
            ir_q        <= '0;
            y_q         <= '0;
            mar_q       <= '0;
            mdr_q       <= '0;
            z_q         <= '0;
            mem_state_q <= MemIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if (gpr_in[i]) gpr_q[i] <= bus_data;
            end
            if (hi_in)  hi_q  <= bus_data;
            if (lo_in)  lo_q  <= bus_data;
            if (pc_in)  pc_q  <= bus_data;
            if (ir_in)  ir_q  <= bus_data;
            if (y_in)   y_q   <= bus_data;
            if (mar_in) mar_q <= bus_data;
            // The bus cannot overwrite MDR while a read is waiting for its data.
            if (rd_ack) begin
                mdr_q <= mem_rdata;
            end else if (mdr_in && !rd_pending) begin
                mdr_q <= bus_data;
            end
            if (eng_res_we) begin
                z_q <= eng_result;
            end else if (z_in && !alu_busy) begin
                z_q <= {{DATA_W{1'b0}}, alu_res};
            end
            mem_state_q <= mem_state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    assign ir_data = ir_q;

endmodule

// File: tb/tb_datapath_seq.sv
module tb_datapath_seq;
    import datapath_pkg::*;

    localparam int W = 32;
    localparam int G = 16;
    localparam int DHi = 0, DLo = 1, DPc = 2, DIr = 3, DY = 4, DMar = 5, DMdr = 6, DGpr = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [G-1:0]  gpr_in, gpr_out;
    logic          hi_in, lo_in, pc_in, ir_in, y_in, mar_in, z_in, mdr_in;
    logic          hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out;
    logic [W-1:0]  inport_data, c_data;
    logic [3:0]    alu_op;
    logic          inc_pc, alu_start;
    logic          alu_busy, alu_done, alu_dz;
    logic          mem_rd, mem_wr, mem_req, mem_we, mem_ack, mem_busy;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic [W-1:0]  bus_data, ir_data;
    logic          bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    datapath_seq #(.DATA_W(W), .NUM_GPR(G)) dut (
        .clk(clk), .reset_n(reset_n), .gpr_in(gpr_in), .gpr_out(gpr_out),
        .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in),
        .mar_in(mar_in), .z_in(z_in), .mdr_in(mdr_in),
        .hi_out(hi_out), .lo_out(lo_out), .pc_out(pc_out), .z_high_out(z_high_out),
        .z_low_out(z_low_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
        .inport_data(inport_data), .c_data(c_data), .alu_op(alu_op), .inc_pc(inc_pc),
        .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done), .alu_dz(alu_dz),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_busy(mem_busy), .bus_data(bus_data), .ir_data(ir_data),
        .bus_err(bus_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic        inc;
        logic [31:0] y;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] z;
        int          cyc;
        logic        dz;
    } eng_vec_t;

    alu_vec_t alu_vecs[15];
    eng_vec_t eng_vecs[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        gpr_in = '0; gpr_out = '0;
        hi_in = 0; lo_in = 0; pc_in = 0; ir_in = 0; y_in = 0; mar_in = 0; z_in = 0; mdr_in = 0;
        hi_out = 0; lo_out = 0; pc_out = 0; z_high_out = 0; z_low_out = 0; mdr_out = 0;
        inport_out = 0; c_out = 0;
        alu_op = 4'h0; inc_pc = 0; alu_start = 0;
        mem_rd = 0; mem_wr = 0; mem_ack = 0;
    endtask

    // Drive one source onto the bus (no clock edge) and capture the bus value.
    task automatic peek(input int src, output logic [31:0] v);
        case (src)
            SrcHi:     hi_out = 1;
            SrcLo:     lo_out = 1;
            SrcPc:     pc_out = 1;
            SrcZHigh:  z_high_out = 1;
            SrcZLow:   z_low_out = 1;
            SrcMdr:    mdr_out = 1;
            SrcInport: inport_out = 1;
            SrcC:      c_out = 1;
            default:   gpr_out[src - SrcGprBase] = 1;
        endcase
        #1;
        v = bus_data;
        hi_out = 0; lo_out = 0; pc_out = 0; z_high_out = 0; z_low_out = 0;
        mdr_out = 0; inport_out = 0; c_out = 0; gpr_out = '0;
    endtask

    task automatic load(input int dst, input logic [31:0] v);
        inport_data = v;
        inport_out  = 1;
        case (dst)
            DHi:     hi_in = 1;
            DLo:     lo_in = 1;
            DPc:     pc_in = 1;
            DIr:     ir_in = 1;
            DY:      y_in = 1;
            DMar:    mar_in = 1;
            DMdr:    mdr_in = 1;
            default: gpr_in[dst - DGpr] = 1;
        endcase
        step();
        clear();
    endtask

    task automatic check_z(input string name, input logic [63:0] exp);
        logic [31:0] zh, zl;
        peek(SrcZHigh, zh);
        peek(SrcZLow, zl);
        check(name, {zh, zl}, exp);
    endtask

    task automatic run_engine(input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, output int cycles);
        load(DY, a);
        inport_data = b;
        inport_out  = 1;
        alu_op      = op;
        alu_start   = 1;
        step();
        clear();
        cycles = 0;
        while (alu_busy && cycles < 100) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        logic [31:0] v;
        int          cyc;
        int          req_cycles;

        alu_vecs[0]  = '{AluAdd, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
        alu_vecs[1]  = '{AluSub, 1'b0, 32'h0000_0010, 32'h0000_0030, 32'hFFFF_FFE0};
        alu_vecs[2]  = '{AluAnd, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        alu_vecs[3]  = '{AluOr,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        alu_vecs[4]  = '{AluShr, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        alu_vecs[5]  = '{AluShl, 1'b0, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        alu_vecs[6]  = '{AluRor, 1'b0, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        alu_vecs[7]  = '{AluRol, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0000_0008};
        alu_vecs[8]  = '{AluNeg, 1'b0, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF};
        alu_vecs[9]  = '{AluNot, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
        alu_vecs[10] = '{4'hC,   1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000};
        alu_vecs[11] = '{AluShr, 1'b0, 32'h0000_0004, 32'h0000_0021, 32'h0000_0002};
        alu_vecs[12] = '{AluRor, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234};
        alu_vecs[13] = '{AluAdd, 1'b1, 32'h0000_1000, 32'h0000_0100, 32'h0000_0104};
        alu_vecs[14] = '{AluRol, 1'b0, 32'h1234_5678, 32'h0000_0008, 32'h3456_7812};

`ifdef DATAPATH_SIGNED_MULDIV_EN
        eng_vecs[0] = '{AluMul, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 32, 1'b0};
        eng_vecs[1] = '{AluDiv, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 32, 1'b0};
        eng_vecs[2] = '{AluDiv, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0};
`else
        eng_vecs[0] = '{AluMul, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, 32, 1'b0};
        eng_vecs[1] = '{AluDiv, 32'd7, 32'hFFFF_FFFE, 64'h0000_0007_0000_0000, 32, 1'b0};
        eng_vecs[2] = '{AluDiv, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 32, 1'b0};
`endif
        eng_vecs[3] = '{AluDiv, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 32, 1'b0};
        eng_vecs[4] = '{AluDiv, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 1'b1};

        // Reset with every load enable, a MUL start and a read strobe asserted.
        clear();
        inport_data = 32'hA5A5_A5A5;
        c_data      = 32'hFFFF_FFF0;
        mem_rdata   = '0;
        reset_n     = 0;
        gpr_in = '1; hi_in = 1; lo_in = 1; pc_in = 1; ir_in = 1; y_in = 1; mar_in = 1;
        z_in = 1; mdr_in = 1; inport_out = 1; alu_op = AluMul; alu_start = 1; mem_rd = 1;
        step();
        step();
        clear();
        reset_n = 1;
        #1;
        check("rst mem_req", mem_req, 0);
        check("rst alu_busy", alu_busy, 0);
        check("rst alu_done", alu_done, 0);
        check("rst bus_err", bus_err, 0);
        check("rst ir", ir_data, 0);
        check("rst mem_addr", mem_addr, 0);
        for (int i = 0; i < G; i++) begin
            peek(SrcGprBase + i, v);
            check($sformatf("rst r%0d", i), v, 0);
        end
        peek(SrcHi, v);  check("rst hi", v, 0);
        peek(SrcLo, v);  check("rst lo", v, 0);
        peek(SrcPc, v);  check("rst pc", v, 0);
        check_z("rst z", 64'h0);
        peek(SrcMdr, v); check("rst mdr", v, 0);

        // Bus transfers and contention.
        load(DGpr + 3, 32'h1234_5678);
        peek(SrcGprBase + 3, v);
        check("r3 load", v, 32'h1234_5678);
        gpr_out[3] = 1; pc_out = 1;
        #1;
        check("contention bus", bus_data, 0);
        check("contention err", bus_err, 1);
        clear();
        #1;
        check("no driver bus", bus_data, 0);
        check("no driver err", bus_err, 0);
        peek(SrcC, v);
        check("c_out", v, 32'hFFFF_FFF0);
        load(DIr, 32'hDEAD_BEEF);
        check("ir load", ir_data, 32'hDEAD_BEEF);

        // Single-cycle ALU table.
        for (int i = 0; i < 15; i++) begin
            load(DY, alu_vecs[i].y);
            inport_data = alu_vecs[i].b;
            inport_out  = 1;
            alu_op      = alu_vecs[i].op;
            inc_pc      = alu_vecs[i].inc;
            z_in        = 1;
            step();
            clear();
            check_z($sformatf("alu vec %0d", i), {32'h0, alu_vecs[i].exp});
        end

        // PC increment through the bus.
        load(DPc, 32'h0000_0100);
        pc_out = 1; inc_pc = 1; alu_op = AluAdd; z_in = 1;
        step();
        clear();
        check_z("pc+4", 64'h0000_0000_0000_0104);

        // Ignored start on a single-cycle op.
        alu_start = 1; alu_op = AluAdd; inport_out = 1;
        step();
        clear();
        check("start non-muldiv", alu_busy, 0);

        // MUL with busy counting and a z_in attempt mid-run.
        load(DY, 32'hFFFF_FFFF);
        inport_data = 32'd2; inport_out = 1; alu_op = AluMul; alu_start = 1;
        step();
        clear();
        cyc = 0;
        while (alu_busy && cyc < 100) begin
            cyc++;
            if (cyc == 4) begin
                inport_data = 32'h77; inport_out = 1; alu_op = AluAdd; z_in = 1;
            end
            step();
            clear();
            if (cyc == 4) begin
                peek(SrcZLow, v);
                check("z_in ignored while busy", v, 32'h104);
            end
        end
        check("mul busy cycles", cyc, 32);
        check("mul done", alu_done, 1);
        check("mul dz", alu_dz, 0);
`ifdef DATAPATH_SIGNED_MULDIV_EN
        check_z("mul -1*2", 64'hFFFF_FFFF_FFFF_FFFE);
`else
        check_z("mul ffffffff*2", 64'h0000_0001_FFFF_FFFE);
`endif
        step();
        check("done one pulse", alu_done, 0);

        // Engine vector table.
        for (int i = 0; i < 5; i++) begin
            run_engine(eng_vecs[i].op, eng_vecs[i].a, eng_vecs[i].b, cyc);
            check($sformatf("eng %0d cycles", i), cyc, eng_vecs[i].cyc);
            check($sformatf("eng %0d done", i), alu_done, 1);
            check($sformatf("eng %0d dz", i), alu_dz, eng_vecs[i].dz);
            check_z($sformatf("eng %0d z", i), eng_vecs[i].z);
        end

        // Move the divide-by-zero result into HI/LO.
        z_high_out = 1; hi_in = 1;
        step();
        clear();
        z_low_out = 1; lo_in = 1;
        step();
        clear();
        peek(SrcHi, v); check("dz hi", v, 32'd5);
        peek(SrcLo, v); check("dz lo", v, 32'hFFFF_FFFF);

        // Memory read with wait states; write strobe and mdr_in during wait are ignored.
        load(DMar, 32'h0000_0010);
        mem_rd = 1;
        step();
        clear();
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) req_cycles++;
            if (i == 0) begin
                check("rd addr", mem_addr, 32'h10);
                mem_wr = 1; mdr_in = 1; inport_out = 1; inport_data = 32'h55;
            end
            if (i == 2) begin
                mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
            end
            step();
            clear();
            if (i == 0) begin
                check("wr during rd ignored", mem_we, 0);
                check("rd addr held", mem_addr, 32'h10);
                peek(SrcMdr, v);
                check("mdr_in ignored during rd", v, 0);
            end
        end
        check("rd req cycles", req_cycles, 3);
        check("rd req drop", mem_req, 0);
        check("rd busy drop", mem_busy, 0);
        peek(SrcMdr, v);
        check("rd mdr", v, 32'hCAFE_F00D);

        // Write (both strobes: write wins) with a zero-wait ack, then a stray ack.
        load(DMdr, 32'hA5A5_A5A5);
        load(DMar, 32'h0000_0020);
        mem_wr = 1; mem_rd = 1;
        step();
        clear();
        check("wr req", mem_req, 1);
        check("wr we", mem_we, 1);
        check("wr addr", mem_addr, 32'h20);
        check("wr wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("wr zero-wait done", mem_req, 0);
        step();
        check("idle ack ignored", mem_req, 0);
        clear();
        peek(SrcMdr, v);
        check("wr keeps mdr", v, 32'hA5A5_A5A5);

        // Reset in the middle of a read and a MUL; a late ack must be ignored.
        load(DY, 32'd3);
        mem_rd = 1; inport_data = 32'd4; inport_out = 1; alu_op = AluMul; alu_start = 1;
        step();
        clear();
        check("pre-rst req", mem_req, 1);
        check("pre-rst busy", alu_busy, 1);
        step();
        step();
        reset_n = 0; mem_ack = 1; mem_rdata = 32'h0000_1234;
        step();
        check("mid rst req", mem_req, 0);
        check("mid rst busy", alu_busy, 0);
        reset_n = 1;
        step();
        check("late ack ignored", mem_req, 0);
        clear();
        peek(SrcMdr, v);
        check("mid rst mdr", v, 0);
        step();
        check("mid rst no done", alu_done, 0);
        check_z("mid rst z", 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Parametrised single-bus CPU datapath with multi-cycle arithmetic and handshaked memory. It provides a configurable-width general-purpose register file, a one-hot-selected shared bus, and the special registers PC, IR, Y, MAR, MDR, HI, LO and the 2×DATA_W Z. It adds a sequential multiply/divide engine and a req/ack memory port, so external RAM may insert wait states. It sits between the control unit, which drives the enables and strobes, and the memory subsystem.

## Interface
Parameters:
- DATA_W, 32, width of bus and all registers (Z is 2×DATA_W); even, ≥8
- NUM_GPR, 16, number of general-purpose registers R0..R(NUM_GPR-1)

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- gpr_in / gpr_out  in  NUM_GPR  per-register load enable / bus drive select
- hi_in, lo_in, pc_in, ir_in, y_in, mar_in, z_in, mdr_in  in  1  load enables
- hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out  in  1  bus drive selects
- inport_data, c_data  in  DATA_W  input-port value, sign-extended constant
- alu_op  in  4  operation code, from datapath_pkg
- inc_pc  in  1  forces ALU A operand to 4 instead of Y
- alu_start  in  1  launches MUL/DIV
- alu_busy, alu_done, alu_dz  out  1  engine busy; one-cycle completion pulse; divide-by-zero flag, valid with done
- mem_rd, mem_wr  in  1  one-cycle transaction strobes
- mem_req, mem_we  out  1  request held until ack; write qualifier
- mem_addr, mem_wdata  out  DATA_W  MAR and MDR snapshots, held during request
- mem_rdata  in  DATA_W; mem_ack  in  1
- mem_busy  out  1  transaction outstanding
- bus_data, ir_data  out  DATA_W  bus value, IR contents
- bus_err  out  1  more than one drive select active

## Operation
- Bus is combinational. Exactly one select drives the selected source. Zero selects gives bus 0. Two or more selects gives bus 0 with bus_err=1.
- Each register loads bus_data on an edge where its enable is high.
- Single-cycle ops (ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, ROR 6, ROL 7, NEG 8, NOT 9):
  - A = inc_pc ? 4 : Y; B = bus_data.
  - The result is zero-extended into Z on z_in.
  - Shift amount is B[log2(DATA_W)-1:0].
  - Codes C–F give 0.
- MUL (A), DIV (B):
  - Operands are taken as A op B when alu_start is high and alu_busy is low.
  - MUL: Z = full 2×DATA_W product.
  - DIV: Z = {remainder, quotient}.
  - Engine FSM: IDLE → RUN (DATA_W iterations, shift-add / restoring) → IDLE, writing Z on the final edge.
  - alu_start while busy is ignored. alu_start with a non-MUL/DIV op is ignored.
  - z_in is ignored while busy.
- Divide by zero: RUN is skipped. Next edge Z = {dividend, all ones}, alu_done=1 and alu_dz=1.
- Memory FSM: M_IDLE → M_WAIT on mem_rd or mem_wr.
  - mem_addr and mem_wdata are latched from MAR and MDR on entry.
  - mem_we=mem_wr. If both strobes are high, the write wins.
  - M_WAIT → M_IDLE on the mem_ack edge. For a read, MDR loads mem_rdata on that edge.
  - Strobes while mem_busy are ignored. mdr_in is ignored during a read.
  - mem_ack in M_IDLE is ignored.
- Reset (any time, including mid-transaction or mid-MUL/DIV):
  - All registers, FSMs and outputs go to 0 on that edge.
  - mem_req drops and any late ack is ignored.

## Timing
- Single-cycle op: operands in cycle k, Z valid after edge k.
- MUL/DIV, start sampled at edge k:
  - alu_busy is high from edge k to edge k+DATA_W.
  - Z is updated at edge k+DATA_W, and alu_done is high for the following cycle.
  - Divide by zero completes at edge k+1.
- Memory:
  - mem_req rises at the edge after the strobe.
  - Read data is available in MDR the cycle after the ack edge.
  - Zero-wait ack gives a 2-cycle transaction.

## Configuration
- DATAPATH_SIGNED_MULDIV_EN defined: MUL/DIV use two's-complement operands.
  - The quotient truncates toward zero.
  - The remainder takes the dividend's sign.
- Not defined: MUL/DIV are unsigned. Single-cycle ops are unaffected.

## Structure
- datapath_pkg holds: alu_op codes, engine and memory FSM state enums, and the bus-source index constants.
- One sub-module, muldiv_seq, contains the iterative engine. It has its own start/busy/done handshake.

## Test plan
- Reset: reset_n=0 with all enables high → every register, Z, mem_req, alu_busy and bus_err are 0.
- Bus: inport_out with inport_data=0x12345678 and gpr_in[3] → R3=0x12345678. gpr_out[3]+pc_out together → bus 0 and bus_err=1.
- PC increment: PC=0x100, pc_out+inc_pc, ADD, z_in → Z low word 0x104.
- MUL: Y=0xFFFFFFFF, bus=2, alu_start → busy exactly 32 cycles, then:
  - unsigned: Z=0x00000001_FFFFFFFE
  - signed: Z=0xFFFFFFFF_FFFFFFFE
- DIV:
  - signed 7/−2 → lo=0xFFFFFFFD, hi=1.
  - 5/0 → alu_done after 1 cycle, alu_dz=1, lo=0xFFFFFFFF, hi=5.
- Memory: MAR=0x10, mem_rd, ack 3 cycles later with rdata 0xCAFEF00D → mem_req high for 3 cycles with addr 0x10, then MDR=0xCAFEF00D. mem_wr during wait is ignored. Reset during wait drops mem_req and leaves MDR at 0.
